// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared definitions for the bit-serial adder: FSM state
//                encodings and the default operand width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full adder cell, purely combinational.
//  Ports       : a, b, c  - addend bits and carry-in
//                sum      - a ^ b ^ c
//                carry    - majority(a, b, c)
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder. Operands are captured on an
//                accepted start, then one bit per clock is added LSB first
//                through a single full_adder with the carry held in a flop.
//                The assembled result is published with a one-cycle done.
//  Ports       : clk      - system clock, rising edge
//                rst      - asynchronous active-high reset
//                start    - begin an addition (accepted in IDLE or DONE)
//                a_in     - operand A, captured on accepted start
//                b_in     - operand B, captured on accepted start
//                cin      - carry-in, captured on accepted start
//                busy     - addition in progress (exactly WIDTH cycles)
//                done     - one-cycle pulse, result valid
//                sum_out  - result sum, held until the next completion
//                cout     - final carry-out, held with sum_out
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q,   state_d;
  logic [WIDTH-1:0]   a_sr_q,    a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,    b_sr_d;
  // Only WIDTH-1 partial sum bits need storing: the final bit comes straight
  // from the adder on the completing edge.
  logic [WIDTH-2:0]   sum_sr_q,  sum_sr_d;
  logic               carry_q,   carry_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [WIDTH-1:0]   sum_out_q, sum_out_d;
  logic               cout_q,    cout_d;

  logic               fa_sum;
  logic               fa_carry;
  logic [WIDTH-1:0]   sum_cat;

  full_adder u_full_adder (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the first
  // addition has reached the LSB of this concatenation.
  assign sum_cat = {fa_sum, sum_sr_q};

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_sr_d  = sum_sr_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_out_d = sum_out_q;
    cout_d    = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d   = a_in;
          b_sr_d   = b_in;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end

      SHIFT: begin
        sum_sr_d = sum_cat[WIDTH-1:1];
        carry_d  = fa_carry;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_out_d = sum_cat;
          cout_d    = fa_carry;
          state_d   = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_sr_q  <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_out_q <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      sum_sr_q  <= sum_sr_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum_out_q <= sum_out_d;
      cout_q    <= cout_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign sum_out = sum_out_q;
  assign cout    = cout_q;

endmodule : serial_adder
`default_nettype wire
